// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions: fetch exception causes, the canonical NOP encoding,
// the fetch RUN/HALT state encoding and the pipeline-register entry layout.
// Reused by imem, fetch, decode and the trap unit.
// Ports: none (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [3:0]  EXC_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0]  EXC_INSTR_ACCESS     = 4'd1;
    localparam logic [31:0] NOP_INSTR_C          = 32'h00000013;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } pipe_entry_t;

    // Instructions are 4-byte aligned; any low address bit set is a fault.
    function automatic logic pc_misaligned(input logic [63:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// -----------------------------------------------------------------------------
// ifetch_if
// Bundles the fetch stage's imem bus, pipeline control inputs and IF/ID output.
// Modports:
//   master - the fetch stage: drives pc_addr and if_*, receives imem_*, stall,
//            redirect_*.
//   slave  - the environment (imem / decode / redirect source): the reverse.
// -----------------------------------------------------------------------------
interface ifetch_if;

    logic [63:0] pc_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        stall;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_exc_en;
    logic [3:0]  if_exc_code;
    logic [63:0] if_exc_val;

    modport master (
        output pc_addr,
        input  imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
        input  stall, redirect_en, redirect_pc,
        output if_valid, if_pc, if_instr, if_exc_en, if_exc_code, if_exc_val
    );

    modport slave (
        input  pc_addr,
        output imem_instr, imem_exc_en, imem_exc_code, imem_exc_val,
        output stall, redirect_en, redirect_pc,
        input  if_valid, if_pc, if_instr, if_exc_en, if_exc_code, if_exc_val
    );

endinterface

// File: rtl/ifetch_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// Generic pipeline register holding one {valid, pc, instr, exc} entry.
// Control priority: rst > i_flush > i_hold > i_load > bubble.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   i_flush    - discard the entry (bubble)
//   i_hold     - keep the entry unchanged
//   i_load     - capture i_entry
//   i_entry    - entry to capture
//   o_entry    - registered entry
// -----------------------------------------------------------------------------
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_hold,
    input  logic        i_load,
    input  pipe_entry_t i_entry,
    output pipe_entry_t o_entry
);

    pipe_entry_t r_entry;

    // Pipeline entry register with flush/hold/load control.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry.valid    <= 1'b0;
            r_entry.pc       <= 64'h0;
            r_entry.instr    <= NOP_INSTR;
            r_entry.exc_en   <= 1'b0;
            r_entry.exc_code <= 4'h0;
            r_entry.exc_val  <= 64'h0;
        end else if (i_flush) begin
            r_entry.valid    <= 1'b0;
            r_entry.instr    <= NOP_INSTR;
            r_entry.exc_en   <= 1'b0;
        end else if (i_hold) begin
            r_entry          <= r_entry;
        end else if (i_load) begin
            r_entry          <= i_entry;
        end else begin
            // Nothing to load: the previous entry has been consumed, emit a bubble.
            r_entry.valid    <= 1'b0;
            r_entry.instr    <= NOP_INSTR;
            r_entry.exc_en   <= 1'b0;
        end
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/ifetch.sv
// -----------------------------------------------------------------------------
// ifetch
// Fetch stage in front of a combinational imem. Owns the PC, checks alignment,
// captures instruction or fault into the IF/ID register and halts after a fault
// so each fetch exception is delivered exactly once.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   bus       - ifetch_if.master: pc_addr out, imem_* in, stall/redirect_* in,
//               if_* out (registered IF/ID entry)
// Parameters:
//   RESET_PC  - PC loaded on reset
//   NOP_INSTR - instruction emitted on bubbles and faults
// -----------------------------------------------------------------------------
module ifetch
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);

    fetch_state_e r_state;
    logic [63:0]  r_pc;
    pipe_entry_t  w_fetch;
    pipe_entry_t  w_if_entry;
    logic         w_load;

    // Fetch result for the current PC, highest-priority fault first.
    always_comb begin
        w_fetch.valid    = 1'b1;
        w_fetch.pc       = r_pc;
        w_fetch.instr    = NOP_INSTR;
        w_fetch.exc_en   = 1'b0;
        w_fetch.exc_code = 4'h0;
        w_fetch.exc_val  = 64'h0;
        if (pc_misaligned(r_pc)) begin
            w_fetch.exc_en   = 1'b1;
            w_fetch.exc_code = EXC_INSTR_MISALIGNED;
            w_fetch.exc_val  = r_pc;
        end else if (bus.imem_exc_en) begin
            w_fetch.exc_en   = 1'b1;
            w_fetch.exc_code = bus.imem_exc_code;
            w_fetch.exc_val  = bus.imem_exc_val;
        end else begin
            w_fetch.instr    = bus.imem_instr;
        end
    end

    // Only RUN loads fresh fetches; HALT feeds bubbles, so imem faults are never re-sampled.
    assign w_load = (r_state == ST_RUN);

    // PC register and RUN/HALT state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
        end else if (bus.redirect_en) begin
            r_state <= ST_RUN;
            r_pc    <= bus.redirect_pc;
        end else if (bus.stall) begin
            r_state <= r_state;
            r_pc    <= r_pc;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_fetch.exc_en) begin
                        // Keep the faulting PC so it stays visible until redirected.
                        r_state <= ST_HALT;
                        r_pc    <= r_pc;
                    end else begin
                        r_state <= ST_RUN;
                        r_pc    <= r_pc + 64'd4;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                    r_pc    <= r_pc;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_pc    <= r_pc;
                end
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.redirect_en),
        .i_hold  (bus.stall),
        .i_load  (w_load),
        .i_entry (w_fetch),
        .o_entry (w_if_entry)
    );

    assign bus.pc_addr     = r_pc;
    assign bus.if_valid    = w_if_entry.valid;
    assign bus.if_pc       = w_if_entry.pc;
    assign bus.if_instr    = w_if_entry.instr;
    assign bus.if_exc_en   = w_if_entry.exc_en;
    assign bus.if_exc_code = w_if_entry.exc_code;
    assign bus.if_exc_val  = w_if_entry.exc_val;

endmodule

// File: tb/tb_ifetch.sv
// -----------------------------------------------------------------------------
// tb_ifetch
// Directed, table-driven bench for ifetch. Each vector gives the inputs for one
// cycle and the outputs expected just after the following rising edge.
// -----------------------------------------------------------------------------
module tb_ifetch;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] IA  = 32'h00500093;
    localparam logic [31:0] IB  = 32'h00a00113;
    localparam logic [31:0] IC  = 32'h002081b3;
    localparam logic [31:0] ID  = 32'h00000033;
    localparam logic [31:0] IE  = 32'h06400193;
    localparam logic [31:0] IX  = 32'hdeadbeef;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ifetch_if bus ();

    ifetch #(
        .RESET_PC  (64'h0),
        .NOP_INSTR (32'h00000013)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [63:0] redir_pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
        logic [63:0] e_pc_addr;
        logic        e_valid;
        logic        full;      // 1: also check if_pc (and code/val when e_exc)
        logic [63:0] e_if_pc;
        logic [31:0] e_instr;
        logic        e_exc;
        logic [3:0]  e_code;
        logic [63:0] e_val;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic s, input logic r, input logic [63:0] rpc,
        input logic [31:0] ins, input logic xe, input logic [3:0] xc, input logic [63:0] xv,
        input logic [63:0] epa, input logic ev, input logic fl, input logic [63:0] epc,
        input logic [31:0] ei, input logic ee, input logic [3:0] ec, input logic [63:0] eval
    );
        vec_t v;
        v.stall = s; v.redir = r; v.redir_pc = rpc; v.instr = ins;
        v.exc_en = xe; v.exc_code = xc; v.exc_val = xv;
        v.e_pc_addr = epa; v.e_valid = ev; v.full = fl; v.e_if_pc = epc;
        v.e_instr = ei; v.e_exc = ee; v.e_code = ec; v.e_val = eval;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [63:0] rpc,
                         input logic [31:0] ins, input logic xe, input logic [3:0] xc,
                         input logic [63:0] xv);
        bus.stall         = s;
        bus.redirect_en   = r;
        bus.redirect_pc   = rpc;
        bus.imem_instr    = ins;
        bus.imem_exc_en   = xe;
        bus.imem_exc_code = xc;
        bus.imem_exc_val  = xv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc_addr"},  bus.pc_addr,            64'h0);
        chk({tag, ".valid"},    {63'h0, bus.if_valid},  64'h0);
        chk({tag, ".if_pc"},    bus.if_pc,              64'h0);
        chk({tag, ".instr"},    {32'h0, bus.if_instr},  {32'h0, NOP});
        chk({tag, ".exc_en"},   {63'h0, bus.if_exc_en}, 64'h0);
        chk({tag, ".exc_code"}, {60'h0, bus.if_exc_code}, 64'h0);
        chk({tag, ".exc_val"},  bus.if_exc_val,         64'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //            stall redir rpc                     instr xe  xc    xv         | pc_addr               v  full if_pc                  instr exc code  val
        vecs[0]  = mk(1'b0, 1'b0, 64'h0,                  IA, 1'b0, 4'h0, 64'h0,       64'h4,                1'b1, 1'b1, 64'h0,                IA,  1'b0, 4'h0, 64'h0);
        vecs[1]  = mk(1'b0, 1'b0, 64'h0,                  IB, 1'b0, 4'h0, 64'h0,       64'h8,                1'b1, 1'b1, 64'h4,                IB,  1'b0, 4'h0, 64'h0);
        vecs[2]  = mk(1'b1, 1'b0, 64'h0,                  IC, 1'b0, 4'h0, 64'h0,       64'h8,                1'b1, 1'b1, 64'h4,                IB,  1'b0, 4'h0, 64'h0);
        vecs[3]  = mk(1'b1, 1'b0, 64'h0,                  IC, 1'b0, 4'h0, 64'h0,       64'h8,                1'b1, 1'b1, 64'h4,                IB,  1'b0, 4'h0, 64'h0);
        vecs[4]  = mk(1'b1, 1'b0, 64'h0,                  IC, 1'b0, 4'h0, 64'h0,       64'h8,                1'b1, 1'b1, 64'h4,                IB,  1'b0, 4'h0, 64'h0);
        vecs[5]  = mk(1'b0, 1'b0, 64'h0,                  IC, 1'b0, 4'h0, 64'h0,       64'hC,                1'b1, 1'b1, 64'h8,                IC,  1'b0, 4'h0, 64'h0);
        vecs[6]  = mk(1'b1, 1'b1, 64'h100,                ID, 1'b0, 4'h0, 64'h0,       64'h100,              1'b0, 1'b0, 64'h0,                NOP, 1'b0, 4'h0, 64'h0);
        vecs[7]  = mk(1'b0, 1'b0, 64'h0,                  IE, 1'b0, 4'h0, 64'h0,       64'h104,              1'b1, 1'b1, 64'h100,              IE,  1'b0, 4'h0, 64'h0);
        vecs[8]  = mk(1'b0, 1'b1, 64'h40000,              IA, 1'b0, 4'h0, 64'h0,       64'h40000,            1'b0, 1'b0, 64'h0,                NOP, 1'b0, 4'h0, 64'h0);
        vecs[9]  = mk(1'b0, 1'b0, 64'h0,                  IX, 1'b1, 4'h1, 64'h40000,   64'h40000,            1'b1, 1'b1, 64'h40000,            NOP, 1'b1, 4'h1, 64'h40000);
        vecs[10] = mk(1'b0, 1'b0, 64'h0,                  IB, 1'b0, 4'h0, 64'h0,       64'h40000,            1'b0, 1'b0, 64'h0,                NOP, 1'b0, 4'h0, 64'h0);
        vecs[11] = mk(1'b0, 1'b0, 64'h0,                  IX, 1'b1, 4'h5, 64'h123,     64'h40000,            1'b0, 1'b0, 64'h0,                NOP, 1'b0, 4'h0, 64'h0);
        vecs[12] = mk(1'b0, 1'b0, 64'h0,                  IB, 1'b0, 4'h0, 64'h0,       64'h40000,            1'b0, 1'b0, 64'h0,                NOP, 1'b0, 4'h0, 64'h0);
        vecs[13] = mk(1'b0, 1'b1, 64'h0,                  IX, 1'b1, 4'h1, 64'h40000,   64'h0,                1'b0, 1'b0, 64'h0,                NOP, 1'b0, 4'h0, 64'h0);
        vecs[14] = mk(1'b0, 1'b0, 64'h0,                  IA, 1'b0, 4'h0, 64'h0,       64'h4,                1'b1, 1'b1, 64'h0,                IA,  1'b0, 4'h0, 64'h0);
        vecs[15] = mk(1'b0, 1'b1, 64'h102,                IB, 1'b0, 4'h0, 64'h0,       64'h102,              1'b0, 1'b0, 64'h0,                NOP, 1'b0, 4'h0, 64'h0);
        vecs[16] = mk(1'b0, 1'b0, 64'h0,                  IA, 1'b1, 4'h1, 64'h999,     64'h102,              1'b1, 1'b1, 64'h102,              NOP, 1'b1, 4'h0, 64'h102);
        vecs[17] = mk(1'b1, 1'b0, 64'h0,                  IA, 1'b0, 4'h0, 64'h0,       64'h102,              1'b1, 1'b1, 64'h102,              NOP, 1'b1, 4'h0, 64'h102);
        vecs[18] = mk(1'b0, 1'b0, 64'h0,                  IA, 1'b0, 4'h0, 64'h0,       64'h102,              1'b0, 1'b0, 64'h0,                NOP, 1'b0, 4'h0, 64'h0);
        vecs[19] = mk(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, IB, 1'b0, 4'h0, 64'h0,      64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0,             NOP, 1'b0, 4'h0, 64'h0);
        vecs[20] = mk(1'b0, 1'b0, 64'h0,                  IA, 1'b0, 4'h0, 64'h0,       64'h0,                1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, IA, 1'b0, 4'h0, 64'h0);
        vecs[21] = mk(1'b0, 1'b0, 64'h0,                  IC, 1'b0, 4'h0, 64'h0,       64'h4,                1'b1, 1'b1, 64'h0,                IC,  1'b0, 4'h0, 64'h0);

        // Reset state
        rst = 1'b1;
        drive(1'b0, 1'b0, 64'h0, IA, 1'b0, 4'h0, 64'h0);
        step();
        step();
        chk_reset("reset");
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].stall, vecs[i].redir, vecs[i].redir_pc, vecs[i].instr,
                  vecs[i].exc_en, vecs[i].exc_code, vecs[i].exc_val);
            step();
            chk($sformatf("v%0d.pc_addr", i), bus.pc_addr, vecs[i].e_pc_addr);
            chk($sformatf("v%0d.valid", i), {63'h0, bus.if_valid}, {63'h0, vecs[i].e_valid});
            chk($sformatf("v%0d.instr", i), {32'h0, bus.if_instr}, {32'h0, vecs[i].e_instr});
            chk($sformatf("v%0d.exc_en", i), {63'h0, bus.if_exc_en}, {63'h0, vecs[i].e_exc});
            if (vecs[i].full) begin
                chk($sformatf("v%0d.if_pc", i), bus.if_pc, vecs[i].e_if_pc);
                if (vecs[i].e_exc) begin
                    chk($sformatf("v%0d.exc_code", i), {60'h0, bus.if_exc_code}, {60'h0, vecs[i].e_code});
                    chk($sformatf("v%0d.exc_val", i), bus.if_exc_val, vecs[i].e_val);
                end
            end
        end

        // Misaligned redirect, then reset while halted and stalled
        drive(1'b0, 1'b1, 64'h6, IA, 1'b0, 4'h0, 64'h0);
        step();
        chk("mis.pc_addr", bus.pc_addr, 64'h6);
        chk("mis.bubble", {63'h0, bus.if_valid}, 64'h0);
        drive(1'b0, 1'b0, 64'h0, IA, 1'b0, 4'h0, 64'h0);
        step();
        chk("mis.valid", {63'h0, bus.if_valid}, 64'h1);
        chk("mis.exc_en", {63'h0, bus.if_exc_en}, 64'h1);
        chk("mis.code", {60'h0, bus.if_exc_code}, 64'h0);
        chk("mis.val", bus.if_exc_val, 64'h6);
        chk("mis.instr", {32'h0, bus.if_instr}, {32'h0, NOP});
        drive(1'b1, 1'b0, 64'h0, IA, 1'b1, 4'h1, 64'h55);
        rst = 1'b1;
        step();
        chk_reset("rst_stall");
        rst = 1'b0;
        drive(1'b0, 1'b0, 64'h0, IA, 1'b0, 4'h0, 64'h0);
        step();
        chk("rst_stall.resume_valid", {63'h0, bus.if_valid}, 64'h1);
        chk("rst_stall.resume_pc", bus.if_pc, 64'h0);
        chk("rst_stall.resume_addr", bus.pc_addr, 64'h4);

        // Reset during HALT after the fault entry was consumed
        drive(1'b0, 1'b1, 64'h40000, IA, 1'b0, 4'h0, 64'h0);
        step();
        drive(1'b0, 1'b0, 64'h0, IX, 1'b1, 4'h1, 64'h40000);
        step();
        chk("halt.exc_en", {63'h0, bus.if_exc_en}, 64'h1);
        drive(1'b0, 1'b0, 64'h0, IX, 1'b0, 4'h0, 64'h0);
        step();
        chk("halt.bubble", {63'h0, bus.if_valid}, 64'h0);
        chk("halt.pc_addr", bus.pc_addr, 64'h40000);
        rst = 1'b1;
        step();
        chk_reset("rst_halt");
        rst = 1'b0;
        drive(1'b0, 1'b0, 64'h0, IB, 1'b0, 4'h0, 64'h0);
        step();
        chk("rst_halt.resume_valid", {63'h0, bus.if_valid}, 64'h1);
        chk("rst_halt.resume_instr", {32'h0, bus.if_instr}, {32'h0, IB});
        chk("rst_halt.resume_addr", bus.pc_addr, 64'h4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
